// File: rtl/hps_disk_mem_slave.sv
// Avalon-MM responder for the HPS DMA bridge: one-sector buffer, status window,
// and the disk request handshake toward the HPS, with a local port for the disk controller.
//
// state  | meaning
// S_IDLE | no operation; waits for op_start
// S_REQ  | disk_op_read/disk_op_write held toward the HPS until a result arrives
// S_DONE | op_done pulse, op_error valid; back to S_IDLE next cycle
module hps_disk_mem_slave #(
  parameter int BUF_WORDS = 128,
  parameter int RD_LAT    = 2
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [31:0]                  mem_address,
  input  logic                         mem_read,
  input  logic                         mem_write,
  input  logic [31:0]                  mem_writedata,
  input  logic [3:0]                   mem_byteenable,
  output logic                         mem_waitrequest,
  output logic [31:0]                  mem_readdata,
  output logic                         mem_readdatavalid,
  input  logic                         op_start,
  input  logic                         op_write,
  input  logic [31:0]                  op_lba,
  output logic                         op_busy,
  output logic                         op_done,
  output logic                         op_error,
  input  logic [$clog2(BUF_WORDS)-1:0] buf_addr,
  input  logic                         buf_we,
  input  logic [31:0]                  buf_wdata,
  output logic [31:0]                  buf_rdata,
  output logic                         disk_op_read,
  output logic                         disk_op_write,
  input  logic                         disk_result_ok,
  input  logic                         disk_result_error
);

  localparam int AW = $clog2(BUF_WORDS);
  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  logic [31:0]   buf_mem [BUF_WORDS];

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [31:0]   lba_q, lba_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          dr_q, dr_d;
  logic          dw_q, dw_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [31:0]   buf_rdata_q, buf_rdata_d;

  logic [1:0]    region;
  logic [AW-1:0] word;
  logic          rd_accept;
  logic          wr_accept;
  logic          mem_wr_buf;
  logic [31:0]   rd_word;
  logic          unused_ok;

  assign region    = mem_address[11:10];
  assign word      = mem_address[AW+1:2];
  assign unused_ok = &{1'b0, mem_address};

  assign mem_waitrequest   = reset | (rd_cnt_q != '0);
  assign mem_readdatavalid = (rd_cnt_q == CW'(1));
  assign mem_readdata      = mem_readdatavalid ? rd_data_q : 32'h0;

  assign rd_accept  = mem_read & ~mem_waitrequest;
  assign wr_accept  = mem_write & ~mem_read & ~mem_waitrequest;
  assign mem_wr_buf = wr_accept & (region == 2'd0);

  always_comb begin
    rd_word = 32'h0;
    if (region == 2'd0) begin
      rd_word = buf_mem[word];
    end else if (region == 2'd1) begin
      case (mem_address[3:2])
        2'd0:    rd_word = {30'b0, dir_q, busy_q};
        2'd1:    rd_word = lba_q;
        default: rd_word = 32'h0;
      endcase
    end
  end

  // Read latency down-counter: loaded on accept, strobe at terminal count 1.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    rd_data_d = rd_data_q;
    if (rd_accept) begin
      rd_cnt_d  = CW'(RD_LAT);
      rd_data_d = rd_word;
    end else if (rd_cnt_q != '0) begin
      rd_cnt_d = rd_cnt_q - CW'(1);
    end
    buf_rdata_d = buf_mem[buf_addr];
  end

  // Buffer is never reset; a colliding local write yields to the mem side.
  always_ff @(posedge clk_sys) begin
    if (buf_we && !(mem_wr_buf && (buf_addr == word))) begin
      buf_mem[buf_addr] <= buf_wdata;
    end
    if (mem_wr_buf) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byteenable[b]) buf_mem[word][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    lba_d   = lba_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    dr_d    = dr_q;
    dw_d    = dw_q;
    case (state_q)
      S_IDLE: begin
        if (op_start) begin
          dir_d   = op_write;
          lba_d   = op_lba;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          dw_d    = op_write;
          dr_d    = ~op_write;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (disk_result_ok || disk_result_error) begin
          dw_d    = 1'b0;
          dr_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = disk_result_error;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      lba_q       <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dr_q        <= 1'b0;
      dw_q        <= 1'b0;
      rd_cnt_q    <= '0;
      rd_data_q   <= 32'h0;
      buf_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      lba_q       <= lba_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      dr_q        <= dr_d;
      dw_q        <= dw_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_data_q   <= rd_data_d;
      buf_rdata_q <= buf_rdata_d;
    end
  end

  assign op_busy       = busy_q;
  assign op_done       = done_q;
  assign op_error      = err_q;
  assign disk_op_read  = dr_q;
  assign disk_op_write = dw_q;
  assign buf_rdata     = buf_rdata_q;

endmodule
